// File: rtl/pulse_blinker_pkg.sv
// pulse_blinker_pkg: shared FSM state type and default blink timings
package pulse_blinker_pkg;
    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
    localparam logic [15:0] DEF_ON_CYCLES  = 16'd1000;
    localparam logic [15:0] DEF_GAP_CYCLES = 16'd1000;
endpackage

// File: rtl/pulse_blinker_timer.sv
// blink_timer: loadable down-counter that stops at zero
// Ports: clk, rst (async, active-high), load/load_val reload the count, zero flags count==0
module blink_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] tmr;
    always_ff @(posedge clk or posedge rst)
        if (rst) tmr <= '0;
        else     tmr <= load ? load_val : zero ? tmr : tmr - CNT_W'(1);
    assign zero = tmr == '0;
endmodule

// File: rtl/pulse_blinker.sv
// pulse_blinker: turns single-cycle strobes into visible fixed-length LED blinks
// Ports: clk, rst (async, active-high), pulse in; led, busy, pending, dropped out.
// Macro PULSE_BLINKER_QUEUE_EN: when defined, pulses during a blink are queued and
// replayed; when undefined, such pulses are dropped and pending is tied to 0.
module pulse_blinker
    import pulse_blinker_pkg::*;
#(
    parameter logic [15:0] ON_CYCLES  = DEF_ON_CYCLES,
    parameter logic [15:0] GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int          CNT_W      = 16,
    parameter int          QUEUE_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pulse,
    output logic               led,
    output logic               busy,
    output logic [QUEUE_W-1:0] pending,
    output logic               dropped
);
    localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(ON_CYCLES - 16'd1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES - 16'd1);
    state_t state, state_nxt;
    logic load, zero, restart, drop_nxt, expire;
    logic [CNT_W-1:0] load_val;
    blink_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );
    assign expire = state == GAP && zero;
`ifdef PULSE_BLINKER_QUEUE_EN
    logic [QUEUE_W-1:0] pend_q, pend_nxt;
    logic inc, consume;
    assign restart = pend_q != '0 || pulse;
    // A pulse landing on an empty-queue GAP expiry starts the blink directly, so it is not queued.
    always_comb begin
        consume  = expire && pend_q != '0;
        inc      = pulse && state != IDLE && !(expire && pend_q == '0);
        pend_nxt = pend_q;
        drop_nxt = 1'b0;
        if (inc && !consume) begin
            if (&pend_q) drop_nxt = 1'b1;
            else         pend_nxt = pend_q + QUEUE_W'(1);
        end else if (consume && !inc) begin
            pend_nxt = pend_q - QUEUE_W'(1);
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) pend_q <= '0;
        else     pend_q <= pend_nxt;
    assign pending = pend_q;
`else
    assign restart  = 1'b0;
    assign drop_nxt = pulse && state != IDLE;
    assign pending  = '0;
`endif
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_val  = ON_LD;
        case (state)
            IDLE: if (pulse) begin
                state_nxt = ON;
                load      = 1'b1;
            end
            ON: if (zero) begin
                state_nxt = GAP;
                load      = 1'b1;
                load_val  = GAP_LD;
            end
            GAP: if (zero) begin
                state_nxt = restart ? ON : IDLE;
                load      = restart;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            led     <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_nxt;
            led     <= state_nxt == ON;
            dropped <= drop_nxt;
        end
    assign busy = state != IDLE;
endmodule
